// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID-stage inputs, EX-stage register outputs,
// stall request and stall-bubble counter.
interface id_ex_stage_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_reg_dst;
  logic             id_alu_src;
  logic             id_mem_to_reg;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_branch;
  logic             id_jump;
  logic             id_sign_zero;
  logic [1:0]       id_alu_op;
  logic [31:0]      id_pc4;
  logic [31:0]      id_rs_data;
  logic [31:0]      id_rt_data;
  logic [15:0]      id_imm;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic [5:0]       id_funct;
  logic             flush;

  logic             ex_valid;
  logic             ex_reg_dst;
  logic             ex_alu_src;
  logic             ex_mem_to_reg;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_branch;
  logic             ex_jump;
  logic             ex_sign_zero;
  logic [1:0]       ex_alu_op;
  logic [31:0]      ex_pc4;
  logic [31:0]      ex_rs_data;
  logic [31:0]      ex_rt_data;
  logic [31:0]      ex_imm32;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic [5:0]       ex_funct;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump, id_sign_zero,
           id_alu_op, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt,
           id_rd, id_funct, flush,
    input  ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_sign_zero,
           ex_alu_op, ex_pc4, ex_rs_data, ex_rt_data, ex_imm32, ex_rs, ex_rt,
           ex_rd, ex_funct, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump, id_sign_zero,
           id_alu_op, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt,
           id_rd, id_funct, flush,
    output ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_sign_zero,
           ex_alu_op, ex_pc4, ex_rs_data, ex_rt_data, ex_imm32, ex_rs, ex_rt,
           ex_rd, ex_funct, stall, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with immediate extension, load-use hazard
// detection, bubble insertion and a saturating stall-bubble counter.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        sign_zero;
    logic [1:0]  alu_op;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
  } ex_bundle_t;

  localparam logic [1:0]       ALU_OP_NOP = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic ex_bundle_t bubble_f();
    ex_bundle_t b;
    b        = '0;
    b.alu_op = ALU_OP_NOP;
    return b;
  endfunction

  function automatic logic [31:0] ext_imm_f(input logic [15:0] imm, input logic zero_ext);
    logic [31:0] r;
    if (zero_ext) begin
      r = {16'h0000, imm};
    end else begin
      r = {{16{imm[15]}}, imm};
    end
    return r;
  endfunction

  ex_bundle_t       ex_q, ex_d, cap_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uses_rt_s, hz_s, stall_s;

  // Load-use hazard against the instruction currently in EX; $zero never conflicts.
  always_comb begin
    uses_rt_s = !bus.id_alu_src | bus.id_mem_write;
    hz_s      = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) & bus.id_valid &
                ((ex_q.rt == bus.id_rs) | (uses_rt_s & (ex_q.rt == bus.id_rt)));
    stall_s   = hz_s & !bus.flush;
  end

  // Raw capture of the ID bundle.
  always_comb begin
    cap_s            = '0;
    cap_s.valid      = bus.id_valid;
    cap_s.reg_dst    = bus.id_reg_dst;
    cap_s.alu_src    = bus.id_alu_src;
    cap_s.mem_to_reg = bus.id_mem_to_reg;
    cap_s.reg_write  = bus.id_reg_write;
    cap_s.mem_read   = bus.id_mem_read;
    cap_s.mem_write  = bus.id_mem_write;
    cap_s.branch     = bus.id_branch;
    cap_s.jump       = bus.id_jump;
    cap_s.sign_zero  = bus.id_sign_zero;
    cap_s.alu_op     = bus.id_alu_op;
    cap_s.pc4        = bus.id_pc4;
    cap_s.rs_data    = bus.id_rs_data;
    cap_s.rt_data    = bus.id_rt_data;
    cap_s.imm32      = ext_imm_f(bus.id_imm, bus.id_sign_zero);
    cap_s.rs         = bus.id_rs;
    cap_s.rt         = bus.id_rt;
    cap_s.rd         = bus.id_rd;
    cap_s.funct      = bus.id_funct;
  end

  // Next EX contents: flush and hazard bubbles win; an invalid slot keeps data but no side effects.
  always_comb begin
    ex_d = cap_s;
    if (bus.flush || hz_s) begin
      ex_d = bubble_f();
    end else if (!bus.id_valid) begin
      ex_d.reg_dst    = 1'b0;
      ex_d.alu_src    = 1'b0;
      ex_d.mem_to_reg = 1'b0;
      ex_d.reg_write  = 1'b0;
      ex_d.mem_read   = 1'b0;
      ex_d.mem_write  = 1'b0;
      ex_d.branch     = 1'b0;
      ex_d.jump       = 1'b0;
      ex_d.sign_zero  = 1'b0;
      ex_d.alu_op     = ALU_OP_NOP;
    end else begin
      ex_d = cap_s;
    end
  end

  // Saturating count of load-use bubbles (flush bubbles excluded via stall_s).
  always_comb begin
    if (stall_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= bubble_f();
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_dst    = ex_q.reg_dst;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_jump       = ex_q.jump;
  assign bus.ex_sign_zero  = ex_q.sign_zero;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_pc4        = ex_q.pc4;
  assign bus.ex_rs_data    = ex_q.rs_data;
  assign bus.ex_rt_data    = ex_q.rt_data;
  assign bus.ex_imm32      = ex_q.imm32;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_funct      = ex_q.funct;
  assign bus.stall         = stall_s;
  assign bus.stall_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;

  logic        v_valid;
  logic [8:0]  v_ctrl;
  logic [1:0]  v_aop;
  logic [31:0] v_pc4, v_rs_data, v_rt_data;
  logic [15:0] v_imm;
  logic [4:0]  v_rs, v_rt, v_rd;
  logic [5:0]  v_funct;
  logic        v_flush;

  int checks = 0;
  int errors = 0;

  id_ex_stage_if #(.CNT_W(16)) if_main ();
  id_ex_stage_if #(.CNT_W(2))  if_sat ();

  id_ex_stage #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(if_main.slave));
  id_ex_stage #(.CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat.slave));

  // ctrl order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump sign_zero
  assign {if_main.id_reg_dst, if_main.id_alu_src, if_main.id_mem_to_reg, if_main.id_reg_write,
          if_main.id_mem_read, if_main.id_mem_write, if_main.id_branch, if_main.id_jump,
          if_main.id_sign_zero} = v_ctrl;
  assign {if_sat.id_reg_dst, if_sat.id_alu_src, if_sat.id_mem_to_reg, if_sat.id_reg_write,
          if_sat.id_mem_read, if_sat.id_mem_write, if_sat.id_branch, if_sat.id_jump,
          if_sat.id_sign_zero} = v_ctrl;
  assign if_main.id_valid = v_valid;     assign if_sat.id_valid = v_valid;
  assign if_main.id_alu_op = v_aop;      assign if_sat.id_alu_op = v_aop;
  assign if_main.id_pc4 = v_pc4;         assign if_sat.id_pc4 = v_pc4;
  assign if_main.id_rs_data = v_rs_data; assign if_sat.id_rs_data = v_rs_data;
  assign if_main.id_rt_data = v_rt_data; assign if_sat.id_rt_data = v_rt_data;
  assign if_main.id_imm = v_imm;         assign if_sat.id_imm = v_imm;
  assign if_main.id_rs = v_rs;           assign if_sat.id_rs = v_rs;
  assign if_main.id_rt = v_rt;           assign if_sat.id_rt = v_rt;
  assign if_main.id_rd = v_rd;           assign if_sat.id_rd = v_rd;
  assign if_main.id_funct = v_funct;     assign if_sat.id_funct = v_funct;
  assign if_main.flush = v_flush;        assign if_sat.flush = v_flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] C_R    = 9'b100100000;
  localparam logic [8:0] C_ANDI = 9'b010100001;
  localparam logic [8:0] C_LW   = 9'b011110000;
  localparam logic [8:0] C_SW   = 9'b010001000;
  localparam logic [8:0] C_ADDI = 9'b010100000;
  localparam logic [8:0] C_BEQ  = 9'b000000100;
  localparam logic [8:0] C_NONE = 9'b000000000;

  typedef struct {
    string       name;
    logic        valid;
    logic [8:0]  ctrl;
    logic [1:0]  aop;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic        flush;
    logic        e_stall;
    logic        e_valid;
    logic [8:0]  e_ctrl;
    logic [1:0]  e_aop;
    logic [31:0] e_imm32;
    logic [4:0]  e_rt;
    logic [15:0] e_cnt;
    logic        chk_data;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(string n, logic vl, logic [8:0] c, logic [1:0] a, logic [15:0] im,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic fl,
                              logic es, logic ev, logic [8:0] ec, logic [1:0] ea,
                              logic [31:0] ei, logic [4:0] ert, logic [15:0] ecnt, logic cd);
    vec_t v;
    v.name = n; v.valid = vl; v.ctrl = c; v.aop = a; v.imm = im;
    v.rs = rs; v.rt = rt; v.rd = rd; v.flush = fl;
    v.e_stall = es; v.e_valid = ev; v.e_ctrl = ec; v.e_aop = ea;
    v.e_imm32 = ei; v.e_rt = ert; v.e_cnt = ecnt; v.chk_data = cd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] ex_ctrl_main();
    return {if_main.ex_reg_dst, if_main.ex_alu_src, if_main.ex_mem_to_reg, if_main.ex_reg_write,
            if_main.ex_mem_read, if_main.ex_mem_write, if_main.ex_branch, if_main.ex_jump,
            if_main.ex_sign_zero};
  endfunction

  task automatic drive(input logic vl, input logic [8:0] c, input logic [1:0] a,
                       input logic [15:0] im, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic fl);
    v_valid = vl; v_ctrl = c; v_aop = a; v_imm = im;
    v_rs = rs; v_rt = rt; v_rd = rd; v_flush = fl;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".valid"}, 32'(if_main.ex_valid), 32'd0);
    chk({tag, ".ctrl"}, 32'(ex_ctrl_main()), 32'd0);
    chk({tag, ".alu_op"}, 32'(if_main.ex_alu_op), 32'd2);
    chk({tag, ".imm32"}, if_main.ex_imm32, 32'd0);
    chk({tag, ".pc4"}, if_main.ex_pc4, 32'd0);
    chk({tag, ".rt"}, 32'(if_main.ex_rt), 32'd0);
    chk({tag, ".stall"}, 32'(if_main.stall), 32'd0);
    chk({tag, ".cnt"}, 32'(if_main.stall_cnt), 32'd0);
    chk({tag, ".sat_cnt"}, 32'(if_sat.stall_cnt), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk("rtype_sext",   1'b1, C_R,    2'b10, 16'h8001, 5'd1, 5'd2, 5'd3, 1'b0,
                  1'b0, 1'b1, C_R,    2'b10, 32'hFFFF8001, 5'd2, 16'd0, 1'b1);
    vecs[1]  = mk("andi_zext",    1'b1, C_ANDI, 2'b11, 16'h8001, 5'd1, 5'd4, 5'd0, 1'b0,
                  1'b0, 1'b1, C_ANDI, 2'b11, 32'h00008001, 5'd4, 16'd0, 1'b1);
    vecs[2]  = mk("lw5",          1'b1, C_LW,   2'b00, 16'h0004, 5'd1, 5'd5, 5'd0, 1'b0,
                  1'b0, 1'b1, C_LW,   2'b00, 32'h00000004, 5'd5, 16'd0, 1'b1);
    vecs[3]  = mk("add_hz_rs",    1'b1, C_R,    2'b10, 16'h0020, 5'd5, 5'd6, 5'd7, 1'b0,
                  1'b1, 1'b0, C_NONE, 2'b10, 32'h00000000, 5'd0, 16'd1, 1'b1);
    vecs[4]  = mk("add_retry",    1'b1, C_R,    2'b10, 16'h0020, 5'd5, 5'd6, 5'd7, 1'b0,
                  1'b0, 1'b1, C_R,    2'b10, 32'h00000020, 5'd6, 16'd1, 1'b1);
    vecs[5]  = mk("lw7",          1'b1, C_LW,   2'b00, 16'h0008, 5'd1, 5'd7, 5'd0, 1'b0,
                  1'b0, 1'b1, C_LW,   2'b00, 32'h00000008, 5'd7, 16'd1, 1'b1);
    vecs[6]  = mk("addi_rt_nohz", 1'b1, C_ADDI, 2'b00, 16'h7FFF, 5'd2, 5'd7, 5'd0, 1'b0,
                  1'b0, 1'b1, C_ADDI, 2'b00, 32'h00007FFF, 5'd7, 16'd1, 1'b1);
    vecs[7]  = mk("lw7b",         1'b1, C_LW,   2'b00, 16'h0000, 5'd1, 5'd7, 5'd0, 1'b0,
                  1'b0, 1'b1, C_LW,   2'b00, 32'h00000000, 5'd7, 16'd1, 1'b1);
    vecs[8]  = mk("sw_hz_rt",     1'b1, C_SW,   2'b00, 16'hFFFC, 5'd2, 5'd7, 5'd0, 1'b0,
                  1'b1, 1'b0, C_NONE, 2'b10, 32'h00000000, 5'd0, 16'd2, 1'b1);
    vecs[9]  = mk("sw_retry",     1'b1, C_SW,   2'b00, 16'hFFFC, 5'd2, 5'd7, 5'd0, 1'b0,
                  1'b0, 1'b1, C_SW,   2'b00, 32'hFFFFFFFC, 5'd7, 16'd2, 1'b1);
    vecs[10] = mk("lw_r0",        1'b1, C_LW,   2'b00, 16'h0000, 5'd1, 5'd0, 5'd0, 1'b0,
                  1'b0, 1'b1, C_LW,   2'b00, 32'h00000000, 5'd0, 16'd2, 1'b1);
    vecs[11] = mk("r_after_lw0",  1'b1, C_R,    2'b10, 16'h0000, 5'd0, 5'd0, 5'd3, 1'b0,
                  1'b0, 1'b1, C_R,    2'b10, 32'h00000000, 5'd0, 16'd2, 1'b1);
    vecs[12] = mk("lw9",          1'b1, C_LW,   2'b00, 16'h0010, 5'd1, 5'd9, 5'd0, 1'b0,
                  1'b0, 1'b1, C_LW,   2'b00, 32'h00000010, 5'd9, 16'd2, 1'b1);
    vecs[13] = mk("flush_hz",     1'b1, C_R,    2'b10, 16'h0000, 5'd9, 5'd1, 5'd2, 1'b1,
                  1'b0, 1'b0, C_NONE, 2'b10, 32'h00000000, 5'd0, 16'd2, 1'b1);
    vecs[14] = mk("post_flush",   1'b1, C_R,    2'b10, 16'h0000, 5'd9, 5'd1, 5'd2, 1'b0,
                  1'b0, 1'b1, C_R,    2'b10, 32'h00000000, 5'd1, 16'd2, 1'b1);
    vecs[15] = mk("lw9b",         1'b1, C_LW,   2'b00, 16'h0010, 5'd1, 5'd9, 5'd0, 1'b0,
                  1'b0, 1'b1, C_LW,   2'b00, 32'h00000010, 5'd9, 16'd2, 1'b1);
    vecs[16] = mk("invalid_slot", 1'b0, C_R,    2'b10, 16'h0000, 5'd9, 5'd1, 5'd2, 1'b0,
                  1'b0, 1'b0, C_NONE, 2'b10, 32'h00000000, 5'd0, 16'd2, 1'b0);
    vecs[17] = mk("lw9c",         1'b1, C_LW,   2'b00, 16'h0010, 5'd1, 5'd9, 5'd0, 1'b0,
                  1'b0, 1'b1, C_LW,   2'b00, 32'h00000010, 5'd9, 16'd2, 1'b1);
    vecs[18] = mk("beq_hz_rt",    1'b1, C_BEQ,  2'b01, 16'h0003, 5'd1, 5'd9, 5'd0, 1'b0,
                  1'b1, 1'b0, C_NONE, 2'b10, 32'h00000000, 5'd0, 16'd3, 1'b1);
    vecs[19] = mk("beq_retry",    1'b1, C_BEQ,  2'b01, 16'h0003, 5'd1, 5'd9, 5'd0, 1'b0,
                  1'b0, 1'b1, C_BEQ,  2'b01, 32'h00000003, 5'd9, 16'd3, 1'b1);

    // Reset asserted mid-cycle with live, non-zero inputs
    rst_n = 1'b1;
    drive(1'b1, C_LW, 2'b00, 16'h1234, 5'd3, 5'd4, 5'd5, 1'b0);
    v_pc4 = 32'h1111_1111; v_rs_data = 32'h2222_2222; v_rt_data = 32'h3333_3333; v_funct = 6'h2A;
    #2 rst_n = 1'b0;
    #1 chk_reset_state("reset_async");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      logic [31:0] pc4_i, rsd_i, rtd_i;
      logic [5:0]  fn_i;
      pc4_i = 32'h0040_0000 + 32'(i) * 32'd4;
      rsd_i = 32'hA000_0000 + 32'(i);
      rtd_i = 32'hB000_0000 + 32'(i);
      fn_i  = 6'h20 + 6'(i);
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].ctrl, vecs[i].aop, vecs[i].imm,
            vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].flush);
      v_pc4 = pc4_i; v_rs_data = rsd_i; v_rt_data = rtd_i; v_funct = fn_i;
      #1 chk({vecs[i].name, ".stall"}, 32'(if_main.stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".valid"}, 32'(if_main.ex_valid), 32'(vecs[i].e_valid));
      chk({vecs[i].name, ".ctrl"}, 32'(ex_ctrl_main()), 32'(vecs[i].e_ctrl));
      chk({vecs[i].name, ".alu_op"}, 32'(if_main.ex_alu_op), 32'(vecs[i].e_aop));
      chk({vecs[i].name, ".cnt"}, 32'(if_main.stall_cnt), 32'(vecs[i].e_cnt));
      chk({vecs[i].name, ".sat_cnt"}, 32'(if_sat.stall_cnt),
          (vecs[i].e_cnt > 16'd3) ? 32'd3 : 32'(vecs[i].e_cnt));
      if (vecs[i].chk_data) begin
        chk({vecs[i].name, ".imm32"}, if_main.ex_imm32, vecs[i].e_imm32);
        chk({vecs[i].name, ".rt"}, 32'(if_main.ex_rt), 32'(vecs[i].e_rt));
        chk({vecs[i].name, ".pc4"}, if_main.ex_pc4, vecs[i].e_valid ? pc4_i : 32'd0);
        chk({vecs[i].name, ".rs_data"}, if_main.ex_rs_data, vecs[i].e_valid ? rsd_i : 32'd0);
        chk({vecs[i].name, ".rt_data"}, if_main.ex_rt_data, vecs[i].e_valid ? rtd_i : 32'd0);
        chk({vecs[i].name, ".rs"}, 32'(if_main.ex_rs), vecs[i].e_valid ? 32'(vecs[i].rs) : 32'd0);
        chk({vecs[i].name, ".rd"}, 32'(if_main.ex_rd), vecs[i].e_valid ? 32'(vecs[i].rd) : 32'd0);
        chk({vecs[i].name, ".funct"}, 32'(if_main.ex_funct), vecs[i].e_valid ? 32'(fn_i) : 32'd0);
      end
    end

    // Reset while a load-use stall is pending: bubble discarded, counter not bumped
    @(negedge clk);
    drive(1'b1, C_LW, 2'b00, 16'h0000, 5'd1, 5'd9, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, C_R, 2'b10, 16'h0000, 5'd9, 5'd1, 5'd2, 1'b0);
    #1 chk("midstall.stall_before", 32'(if_main.stall), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_reset_state("midstall_reset");
    @(posedge clk);
    #1 chk("midstall.cnt_after_edge", 32'(if_main.stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Five load-use stalls: 16-bit counter counts, 2-bit counter saturates
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, C_LW, 2'b00, 16'h0000, 5'd1, 5'd5, 5'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, C_R, 2'b10, 16'h0000, 5'd5, 5'd6, 5'd7, 1'b0);
      #1 chk($sformatf("sat%0d.stall", k), 32'(if_main.stall), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.cnt", k), 32'(if_main.stall_cnt), 32'(k));
      chk($sformatf("sat%0d.sat_cnt", k), 32'(if_sat.stall_cnt), (k > 3) ? 32'd3 : 32'(k));
      chk($sformatf("sat%0d.bubble_valid", k), 32'(if_sat.ex_valid), 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
